// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with carry-in, split into STAGES ripple-carry chunks with valid/ready on both sides.
// Define ADD_SUB_EN to add a 'sub' input that turns the block into an adder/subtractor.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [STAGES-1:0] am_q, am_d;
    logic [STAGES-1:0] bm_q, bm_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];

    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_res [STAGES];
    logic [STAGES-1:0] src_c, src_am, src_bm, src_v;
    logic [CW:0]       chunk   [STAGES];
    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;
    logic              en;

    always_comb begin
        en    = !vld_q[STAGES-1] || out_ready;
        b_eff = b;
        c_eff = c_in;
`ifdef ADD_SUB_EN
        // a - b - c_in == a + ~b + ~c_in modulo 2^WIDTH, with c_out meaning "no borrow"
        if (sub) begin
            b_eff = ~b;
            c_eff = ~c_in;
        end
`endif
        src_a[0]   = a;
        src_b[0]   = b_eff;
        src_res[0] = '0;
        src_c[0]   = c_eff;
        src_am[0]  = a[WIDTH-1];
        src_bm[0]  = b_eff[WIDTH-1];
        src_v[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = opa_q[k-1];
            src_b[k]   = opb_q[k-1];
            src_res[k] = res_q[k-1];
            src_c[k]   = cy_q[k-1];
            src_am[k]  = am_q[k-1];
            src_bm[k]  = bm_q[k-1];
            src_v[k]   = vld_q[k-1];
        end

        vld_d = vld_q;
        cy_d  = cy_q;
        am_d  = am_q;
        bm_d  = bm_q;
        opa_d = opa_q;
        opb_d = opb_q;
        res_d = res_q;
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
                       + {{CW{1'b0}}, src_c[k]};
        end

        if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k] = src_v[k];
                cy_d[k]  = chunk[k][CW];
                am_d[k]  = src_am[k];
                bm_d[k]  = src_bm[k];
                res_d[k] = src_res[k];
                res_d[k][k*CW +: CW] = chunk[k][CW-1:0];
                // consumed operand chunks are zeroed so their flops reduce to constants
                opa_d[k] = src_a[k];
                opb_d[k] = src_b[k];
                for (int j = 0; j <= k; j++) begin
                    opa_d[k][j*CW +: CW] = '0;
                    opb_d[k][j*CW +: CW] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            am_q  <= '0;
            bm_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            am_q  <= am_d;
            bm_q  <= bm_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            res_q <= res_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
    assign ovf       = (am_q[STAGES-1] == bm_q[STAGES-1]) && (sum[WIDTH-1] != am_q[STAGES-1]);

endmodule
